// File: rtl/sub12_pkg.sv
// Shared definitions for the serial 12-bit subtractor: slice geometry and
// the controller state encoding.
package sub12_pkg;

   localparam int SLICE_W  = 4;
   localparam int N_SLICES = 3;
   localparam int IDX_W    = 2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/sub12_serial_if.sv
// Operand/result bus of sub12_serial.
//
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both high. The operand side (in_valid/in_ready) carries A, B and b0;
// the result side (out_valid/out_ready) carries D, b12 and ovf. A producer
// holding valid keeps its payload stable until the transfer. Ready never
// depends combinationally on valid.
// The controller state is also exported so that checkers can observe it.
interface sub12_serial_if
   import sub12_pkg::*;
   ;
   logic        in_valid;
   logic        in_ready;
   logic [12:1] A;
   logic [12:1] B;
   logic        b0;
   logic        out_valid;
   logic        out_ready;
   logic [12:1] D;
   logic        b12;
   logic        ovf;
   state_t      state;

   modport master (
      output in_valid, A, B, b0, out_ready,
      input  in_ready, out_valid, D, b12, ovf, state
   );

   modport slave (
      input  in_valid, A, B, b0, out_ready,
      output in_ready, out_valid, D, b12, ovf, state
   );

endinterface

// File: rtl/sub12_serial_adder4.sv
// 4-bit ripple-carry adder slice shared by the serial datapath.
module adder4
   import sub12_pkg::*;
(
   input  logic [SLICE_W:1] a,
   input  logic [SLICE_W:1] b,
   input  logic             c0,
   output logic [SLICE_W:1] s,
   output logic             c4
);

   logic [SLICE_W:0] c;

   // Ripple the carry through the four bit positions.
   always_comb begin
      c    = '0;
      s    = '0;
      c[0] = c0;
      for (int i = 1; i <= SLICE_W; i++) begin
         s[i] = a[i] ^ b[i] ^ c[i-1];
         c[i] = (a[i] & b[i]) | (a[i] & c[i-1]) | (b[i] & c[i-1]);
      end
      c4 = c[SLICE_W];
   end

endmodule

// File: rtl/sub12_serial.sv
// Serial 12-bit subtractor: D = A - B - b0 computed as A + ~B + ~b0,
// one 4-bit slice per clock through a single adder4 and a carry register.
module sub12_serial
   import sub12_pkg::*;
(
   input  logic           clk,
   input  logic           rst,
   sub12_serial_if.slave  bus
);

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   idx_q;
   logic [12:1]        a_q, b_q, d_q;
   logic               cy_q, b12_q, ovf_q;
   logic [SLICE_W:1]   a_sl, b_sl, sum;
   logic               cout;
   logic               last_slice;

   assign last_slice = (idx_q == IDX_W'(N_SLICES - 1));

   // Select the current operand slices from the latched operands.
   always_comb begin
      a_sl = a_q[4:1];
      b_sl = b_q[4:1];
      case (idx_q)
         2'd1: begin
            a_sl = a_q[8:5];
            b_sl = b_q[8:5];
         end
         2'd2: begin
            a_sl = a_q[12:9];
            b_sl = b_q[12:9];
         end
         default: ;
      endcase
   end

   adder4 u_adder (
      .a  (a_sl),
      .b  (~b_sl),
      .c0 (cy_q),
      .s  (sum),
      .c4 (cout)
   );

   // Controller next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.in_valid)  state_d = CALC;
         CALC:    if (last_slice)    state_d = DONE;
         DONE:    if (bus.out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Controller state register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Operand capture, slice iteration and result registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_q   <= '0;
         b_q   <= '0;
         d_q   <= '0;
         idx_q <= '0;
         cy_q  <= 1'b0;
         b12_q <= 1'b0;
         ovf_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.in_valid) begin
                  a_q   <= bus.A;
                  b_q   <= bus.B;
                  cy_q  <= ~bus.b0;
                  idx_q <= '0;
               end
            end
            CALC: begin
               case (idx_q)
                  2'd0:    d_q[4:1]  <= sum;
                  2'd1:    d_q[8:5]  <= sum;
                  default: d_q[12:9] <= sum;
               endcase
               cy_q <= cout;
               if (last_slice) begin
                  idx_q <= '0;
                  // A carry out of the top slice means no borrow.
                  b12_q <= ~cout;
                  ovf_q <= (a_q[12] != b_q[12]) && (sum[SLICE_W] != a_q[12]);
               end else begin
                  idx_q <= idx_q + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.in_ready  = (state_q == IDLE) && !rst;
   assign bus.out_valid = (state_q == DONE);
   assign bus.D         = d_q;
   assign bus.b12       = b12_q;
   assign bus.ovf       = ovf_q;
   assign bus.state     = state_q;

endmodule

// File: tb/tb_sub12_serial.sv
// Directed bench for sub12_serial.
module tb_sub12_serial;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   sub12_serial_if bus ();

   sub12_serial dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Present operands at a falling edge and let the next rising edge accept.
   task automatic start_op(input logic [12:1] a, input logic [12:1] b, input logic bb);
      @(negedge clk);
      bus.A        = a;
      bus.B        = b;
      bus.b0       = bb;
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
   endtask

   // Count edges after accept until out_valid rises (bounded).
   task automatic wait_done(output int lat);
      lat = 0;
      while (!bus.out_valid && lat < 10) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   // One transfer edge with out_ready high.
   task automatic transfer();
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (bus.in_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_in_ready actual=%b required=0", bus.in_ready);
      end
      checks++;
      if (bus.out_valid !== 1'b0 || bus.D !== 12'h000 || bus.b12 !== 1'b0 || bus.ovf !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs actual=%b/%h/%b/%b required=0/000/0/0",
                  bus.out_valid, bus.D, bus.b12, bus.ovf);
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      checks++;
      if (bus.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_release_in_ready actual=%b required=1", bus.in_ready);
      end
   endtask

   task automatic test_vectors();
      logic [12:1] va [4];
      logic [12:1] vb [4];
      logic        vc [4];
      logic [12:1] ed [4];
      logic        eb [4];
      logic        eo [4];
      int          lat;
      va[0] = 12'h005; vb[0] = 12'h003; vc[0] = 1'b0; ed[0] = 12'h002; eb[0] = 1'b0; eo[0] = 1'b0;
      va[1] = 12'h000; vb[1] = 12'h001; vc[1] = 1'b0; ed[1] = 12'hFFF; eb[1] = 1'b1; eo[1] = 1'b0;
      va[2] = 12'h800; vb[2] = 12'h001; vc[2] = 1'b0; ed[2] = 12'h7FF; eb[2] = 1'b0; eo[2] = 1'b1;
      va[3] = 12'h100; vb[3] = 12'h0FF; vc[3] = 1'b1; ed[3] = 12'h000; eb[3] = 1'b0; eo[3] = 1'b0;
      for (int i = 0; i < 4; i++) begin
         start_op(va[i], vb[i], vc[i]);
         wait_done(lat);
         checks++;
         if (lat !== 3) begin
            errors++;
            $display("FAIL vec%0d_latency actual=%0d required=3", i, lat);
         end
         checks++;
         if (bus.D !== ed[i] || bus.b12 !== eb[i] || bus.ovf !== eo[i]) begin
            errors++;
            $display("FAIL vec%0d_result actual=%h/%b/%b required=%h/%b/%b",
                     i, bus.D, bus.b12, bus.ovf, ed[i], eb[i], eo[i]);
         end
         checks++;
         if (bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL vec%0d_in_ready_in_done actual=%b required=0", i, bus.in_ready);
         end
         transfer();
         checks++;
         if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL vec%0d_after_transfer actual=%b/%b required=1/0",
                     i, bus.in_ready, bus.out_valid);
         end
      end
   endtask

   task automatic test_backpressure();
      int lat;
      start_op(12'hABC, 12'h123, 1'b0);
      wait_done(lat);
      checks++;
      if (lat !== 3) begin
         errors++;
         $display("FAIL bp_latency actual=%0d required=3", lat);
      end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         bus.in_valid = ~bus.in_valid;
         bus.A        = bus.A + 12'h111;
         bus.B        = bus.B ^ 12'h5A5;
         bus.b0       = ~bus.b0;
         @(posedge clk);
         #1;
         checks++;
         if (bus.D !== 12'h999 || bus.b12 !== 1'b0 || bus.ovf !== 1'b0 ||
             bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_hold%0d actual=%h/%b/%b rdy=%b vld=%b required=999/0/0 rdy=0 vld=1",
                     i, bus.D, bus.b12, bus.ovf, bus.in_ready, bus.out_valid);
         end
      end
      bus.in_valid = 1'b0;
      transfer();
      checks++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.D !== 12'h999) begin
         errors++;
         $display("FAIL bp_release actual=rdy %b vld %b D %h required=rdy 1 vld 0 D 999",
                  bus.in_ready, bus.out_valid, bus.D);
      end
   endtask

   task automatic test_reset_mid_calc();
      int lat;
      logic seen_valid;
      start_op(12'h555, 12'h111, 1'b0);
      // First CALC edge, then reset across the second CALC edge.
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      checks++;
      if (bus.in_ready !== 1'b1 || bus.D !== 12'h000 || bus.b12 !== 1'b0 || bus.ovf !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid_state actual=rdy %b D %h b12 %b ovf %b required=rdy 1 D 000 b12 0 ovf 0",
                  bus.in_ready, bus.D, bus.b12, bus.ovf);
      end
      seen_valid = 1'b0;
      repeat (4) begin
         @(posedge clk);
         #1;
         if (bus.out_valid) seen_valid = 1'b1;
      end
      checks++;
      if (seen_valid !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid_no_result actual=%b required=0", seen_valid);
      end
      start_op(12'h010, 12'h001, 1'b0);
      wait_done(lat);
      checks++;
      if (lat !== 3 || bus.D !== 12'h00F || bus.b12 !== 1'b0 || bus.ovf !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid_next_op actual=lat %0d %h/%b/%b required=lat 3 00F/0/0",
                  lat, bus.D, bus.b12, bus.ovf);
      end
      transfer();
   endtask

   initial begin
      checks        = 0;
      errors        = 0;
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.A         = '0;
      bus.B         = '0;
      bus.b0        = 1'b0;
      test_reset();
      test_vectors();
      test_backpressure();
      test_reset_mid_calc();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sub12_serial.md
# sub12_serial

Sequential 12-bit two's-complement subtractor computing D = A − B − b0 one 4-bit slice per clock. It reuses a single `adder4` slice through an internal carry register. Valid/ready handshakes sit on both the operand and result sides. It is the inverse arithmetic partner of the 12-bit ripple adder in the datapath library, intended for area-constrained paths where three cycles of latency are acceptable.

## Interface
Parameters:
- none; width fixed at 12 bits (three 4-bit slices), bit indexing [12:1] as in the adder family

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operands valid
- in_ready  out  1  block can accept operands
- A  in  [12:1]  minuend
- B  in  [12:1]  subtrahend
- b0  in  1  borrow-in (1 = subtract one more)
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- D  out  [12:1]  difference A − B − b0, mod 2^12
- b12  out  1  borrow-out: 1 iff unsigned A < B + b0
- ovf  out  1  signed overflow

## Operation
- Subtraction is implemented as A + ~B + ~b0, one slice per cycle, through one `adder4`.
- The internal carry register `cy` is initialised to ~b0 on accept.
- On each CALC cycle idx, the adder computes A[4idx+4:4idx+1] + ~B[same] + cy.
- The 4-bit sum is written into the D slice and the slice carry-out is written into `cy`.
- States:
  - IDLE: in_ready=1. When in_valid, at the edge: latch A, B, ~b0; set idx=0; go to CALC.
  - CALC: in_ready=0, out_valid=0. Compute slice idx and increment idx. After idx=2, go to DONE; b12 ← ~carry-out of slice 2; ovf ← (A[12]≠B[12]) && (D[12]≠A[12]).
  - DONE: out_valid=1. On out_valid && out_ready, go to IDLE at the edge.
- in_valid is ignored outside IDLE. Operands are captured only at the accept edge, so A, B and b0 may change afterwards.
- D, b12 and ovf must hold stable for the whole of DONE.
- D, b12 and ovf keep their last value after the transfer. They are meaningful only while out_valid=1.

## Timing
- Reset (rst=1 at an edge): state=IDLE, idx=0, cy=0, D=0, b12=0, ovf=0, out_valid=0.
- in_ready=0 while rst is high, and 1 in the first cycle after rst deasserts.
- Latency: the accept edge is edge 0; the CALC edges are 1, 2 and 3; out_valid is high from the cycle after edge 3.
- Minimum initiation interval is 5 cycles: accept, 3×CALC, transfer edge in DONE, then back in IDLE.
- in_ready is never high in the same cycle as out_valid, so there are no overlapping operations.
- Backpressure: with out_ready low, the block stays in DONE indefinitely with outputs frozen.
- Reset mid-CALC or mid-DONE: the operation is aborted, no result is presented, and all outputs take their reset values.
- No combinational path from in_valid or out_ready to any output. in_ready and out_valid are decoded from state registers only.

## Structure
- Shared package `sub12_pkg` holds:
  - state encoding: IDLE=2'd0, CALC=2'd1, DONE=2'd2
  - SLICE_W=4, N_SLICES=3, IDX_W=2
- Sub-module: one instance of the existing `adder4`. Its B input is the inverted B slice and its c0 input is `cy`.
- Slice selection is done with an idx-driven mux on the latched operands. The demux writes into the D register.

## Test plan
- A=12'h005, B=12'h003, b0=0 → D=12'h002, b12=0, ovf=0. out_valid rises exactly 3 edges after accept.
- A=12'h000, B=12'h001, b0=0 → D=12'hFFF, b12=1, ovf=0. The borrow ripples through all three slices.
- A=12'h800, B=12'h001, b0=0 → D=12'h7FF, b12=0, ovf=1 (−2048 − 1 overflows).
- A=12'h100, B=12'h0FF, b0=1 → D=12'h000, b12=0, ovf=0. Checks borrow-in and the slice-1 boundary.
- Backpressure: complete A=12'hABC, B=12'h123 (D=12'h999). Hold out_ready=0 for 5 cycles while toggling in_valid and the operands. Required: D, b12 and ovf stay stable, in_ready=0, and no new accept. Release out_ready; the transfer occurs and in_ready=1 in the next cycle.
- Assert rst for one cycle during the second CALC cycle. Required: out_valid never rises for that operation, in_ready=1 the cycle after rst falls, and the next operation (12'h010 − 12'h001 → 12'h00F) is correct.
